// File: rtl/e_mdu_ctrl_pkg.sv
// Shared HL-op encodings, op-class helpers and
// the sequencer state type for the E-stage MDU.
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    HL_NOWRITE = 4'd0,
    HL_MULT    = 4'd1,
    HL_MULTU   = 4'd2,
    HL_DIV     = 4'd3,
    HL_DIVU    = 4'd4,
    HL_MTHI    = 4'd5,
    HL_MTLO    = 4'd6,
    HL_MFHI    = 4'd7,
    HL_MFLO    = 4'd8
  } hl_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_st_e;

  function automatic logic is_start(
    input logic [3:0] op
  );
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic logic is_mul(
    input logic [3:0] op
  );
    return (op == 4'd1) || (op == 4'd2);
  endfunction

  function automatic logic is_any_hl(
    input logic [3:0] op
  );
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/e_mdu_latency_cnt.sv
// Loadable down-counter; term_o flags the last
// counted cycle so the owner can retire the op.
module e_mdu_latency_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins; otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q > W'(1)) begin
      cnt_d = cnt_q - W'(1);
    end else if (cnt_q == W'(1)) begin
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == W'(1));

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage sequencer for the HI/LO mul/div unit:
// issue, latency tracking, D stall, error, stats.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_hl_op,
  input  logic             e_flush,
  input  logic [3:0]       d_hl_op,
  output logic [3:0]       mdu_op,
  output logic             mdu_busy,
  output logic             stall_d,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  mdu_st_e          state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             idle;
  logic             e_live;
  logic             issue_ok;
  logic             start;
  logic             term;
  logic [CW-1:0]    load_val;
  logic [CW-1:0]    cnt_unused;

  assign idle     = (state_q == ST_IDLE);
  assign e_live   = e_valid & ~e_flush;
  assign issue_ok = e_live & idle;
  assign start    = issue_ok & is_start(e_hl_op);
  assign load_val = is_mul(e_hl_op) ?
                    CW'(MULT_CYCLES) :
                    CW'(DIV_CYCLES);

  e_mdu_latency_cnt #(
    .W (CW)
  ) u_lat (
    .clk    (clk),
    .reset  (reset),
    .load_i (start),
    .val_i  (load_val),
    .cnt_o  (cnt_unused),
    .term_o (term)
  );

  // next state: launch from IDLE, retire on terminal count
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = is_mul(e_hl_op) ?
                    ST_MUL : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (term) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sticky error and saturating stall counter
  always_comb begin
    err_d  = err_q |
             (e_live & ~idle &
              (e_hl_op != HL_NOWRITE));
    scnt_d = scnt_q;
    if (stall_d && !(&scnt_q)) begin
      scnt_d = scnt_q + CNT_W'(1);
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      scnt_q  <= scnt_d;
    end
  end

  assign mdu_op    = issue_ok ? e_hl_op : HL_NOWRITE;
  assign mdu_busy  = start | ~idle;
  assign stall_d   = is_any_hl(d_hl_op) & mdu_busy;
  assign done      = ~idle & term;
  assign err       = err_q;
  assign stall_cnt = scnt_q;

endmodule
